// File: rtl/decoder_x4_pkg.sv
// Shared types and constants for the 2-to-4 code decoder and its hold timer.
package decoder_x4_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   typedef logic [1:0] code_t;

   localparam int unsigned HOLD_CYCLES_DEF = 4;
   localparam int unsigned CNT_W           = 8;
   localparam int unsigned EVT_W           = 8;

   localparam logic [EVT_W-1:0] EVT_MAX = '1;

   function automatic logic [3:0] decode_onehot(input code_t code);
      return 4'b0001 << code;
   endfunction

   // Event counter sticks at its maximum instead of wrapping.
   function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
      return (v == EVT_MAX) ? v : v + EVT_W'(1);
   endfunction

endpackage

// File: rtl/decoder_x4_hold_timer.sv
// Hold-duration down-counter; done flags the terminal count of zero.
module hold_timer
   import decoder_x4_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/decoder_x4.sv
// Decodes a priority-encoder code {z1,z2} into a one-hot pulse held for
// HOLD_CYCLES cycles, with sticky overrun detection and a saturating event count.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | x = 0, ready = 1; a code with y = 1 is accepted
//   ST_HOLD | x holds the decoded one-hot; y = 1 here is an overrun
module decoder_x4
   import decoder_x4_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             z1,
   input  logic             z2,
   input  logic             y,
   input  logic             clr_ovr,
   output logic             ready,
   output logic [3:0]       x,
   output logic             active,
   output logic             ovr,
   output logic [EVT_W-1:0] evt_cnt
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t           state_q;
   state_t           state_d;
   logic [3:0]       x_q;
   logic [3:0]       x_d;
   logic             ovr_q;
   logic             ovr_d;
   logic [EVT_W-1:0] evt_q;
   logic [EVT_W-1:0] evt_d;

   logic             accept;
   logic             overrun;
   logic             timer_done;

   assign accept  = (state_q == ST_IDLE) && y;
   assign overrun = (state_q == ST_HOLD) && y;

   hold_timer u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (HOLD_LOAD),
      .done     (timer_done)
   );

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      evt_d   = evt_q;
      ovr_d   = ovr_q;

      case (state_q)
         ST_IDLE: begin
            if (y) begin
               state_d = ST_HOLD;
               x_d     = decode_onehot({z1, z2});
               evt_d   = sat_inc(evt_q);
            end
         end
         ST_HOLD: begin
            if (timer_done) begin
               state_d = ST_IDLE;
               x_d     = 4'b0000;
            end
         end
         default: begin
            state_d = ST_IDLE;
            x_d     = 4'b0000;
         end
      endcase

      // A fresh overrun outranks a clear in the same cycle.
      if (overrun) begin
         ovr_d = 1'b1;
      end else if (clr_ovr) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         x_q     <= 4'b0000;
         ovr_q   <= 1'b0;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         ovr_q   <= ovr_d;
         evt_q   <= evt_d;
      end
   end

   assign ready   = (state_q == ST_IDLE);
   assign x       = x_q;
   assign active  = |x_q;
   assign ovr     = ovr_q;
   assign evt_cnt = evt_q;

endmodule

// File: tb/tb_decoder_x4.sv
// Directed-vector bench for decoder_x4: default hold of 4 plus a HOLD_CYCLES = 1 instance.
module tb_decoder_x4;

   logic       clk = 1'b0;
   logic       rst, z1, z2, y, clr_ovr;
   logic       ready, active, ovr;
   logic [3:0] x;
   logic [7:0] evt_cnt;

   logic       rst_1, z1_1, z2_1, y_1, clr_ovr_1;
   logic       ready_1, active_1, ovr_1;
   logic [3:0] x_1;
   logic [7:0] evt_cnt_1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decoder_x4 u_dut (
      .clk     (clk),
      .rst     (rst),
      .z1      (z1),
      .z2      (z2),
      .y       (y),
      .clr_ovr (clr_ovr),
      .ready   (ready),
      .x       (x),
      .active  (active),
      .ovr     (ovr),
      .evt_cnt (evt_cnt)
   );

   decoder_x4 #(.HOLD_CYCLES(1)) u_dut_1 (
      .clk     (clk),
      .rst     (rst_1),
      .z1      (z1_1),
      .z2      (z2_1),
      .y       (y_1),
      .clr_ovr (clr_ovr_1),
      .ready   (ready_1),
      .x       (x_1),
      .active  (active_1),
      .ovr     (ovr_1),
      .evt_cnt (evt_cnt_1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_code(input logic [1:0] c);
      z1 = c[1];
      z2 = c[0];
   endtask

   initial begin
      logic [1:0] code;
      logic [3:0] exp_x;

      rst = 1'b1; z1 = 1'b0; z2 = 1'b0; y = 1'b0; clr_ovr = 1'b0;
      rst_1 = 1'b1; z1_1 = 1'b0; z2_1 = 1'b0; y_1 = 1'b0; clr_ovr_1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      rst_1 = 1'b0;

      check("rst_x",      x,       4'b0000);
      check("rst_ready",  ready,   1'b1);
      check("rst_active", active,  1'b0);
      check("rst_ovr",    ovr,     1'b0);
      check("rst_evt",    evt_cnt, 8'd0);

      // y = 0 ignores the code lines
      set_code(2'b11);
      tick();
      check("y0_x",     x,       4'b0000);
      check("y0_ready", ready,   1'b1);
      check("y0_evt",   evt_cnt, 8'd0);

      // single code 10
      set_code(2'b10);
      y = 1'b1;
      tick();
      y = 1'b0;
      check("c10_x_n1",     x,       4'b0100);
      check("c10_evt",      evt_cnt, 8'd1);
      check("c10_active",   active,  1'b1);
      check("c10_ready_n1", ready,   1'b0);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check("c10_x_hold", x, 4'b0100);
      end
      tick();
      check("c10_x_n5",      x,      4'b0000);
      check("c10_ready_n5",  ready,  1'b1);
      check("c10_active_n5", active, 1'b0);

      // codes 00..11 back to back, one gap cycle each
      for (int c = 0; c < 4; c++) begin
         code = 2'(c);
         exp_x = 4'b0001 << c;
         set_code(code);
         y = 1'b1;
         tick();
         y = 1'b0;
         for (int h = 0; h < 4; h++) begin
            check("seq_x_hold", x, exp_x);
            tick();
         end
         check("seq_x_gap",     x,     4'b0000);
         check("seq_ready_gap", ready, 1'b1);
      end
      check("seq_evt", evt_cnt, 8'd5);

      // overrun during HOLD, then clr_ovr alone
      set_code(2'b01);
      y = 1'b1;
      tick();                              // N+1
      y = 1'b0;
      tick();                              // N+2
      set_code(2'b11);
      y = 1'b1;
      tick();                              // N+3
      y = 1'b0;
      check("ovr_x_n3",   x,       4'b0010);
      check("ovr_set_n3", ovr,     1'b1);
      check("ovr_evt",    evt_cnt, 8'd6);
      tick();                              // N+4
      check("ovr_x_n4",   x,       4'b0010);
      tick();                              // N+5
      check("ovr_x_n5",   x,       4'b0000);
      check("ovr_sticky", ovr,     1'b1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      check("ovr_cleared", ovr, 1'b0);

      // overrun and clr_ovr in the same cycle: set wins
      set_code(2'b00);
      y = 1'b1;
      tick();                              // N+1, HOLD
      clr_ovr = 1'b1;
      tick();                              // N+2
      y = 1'b0;
      clr_ovr = 1'b0;
      check("ovr_set_wins", ovr, 1'b1);
      check("ovr_sw_x",     x,   4'b0001);
      tick();
      tick();
      tick();                              // N+5, IDLE
      check("ovr_sw_ready", ready, 1'b1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      check("ovr_sw_clear", ovr, 1'b0);

      // reset in the middle of a HOLD, with y also high
      set_code(2'b11);
      y = 1'b1;
      tick();                              // N+1
      y = 1'b0;
      check("rsth_x_n1", x, 4'b1000);
      tick();                              // N+2
      rst = 1'b1;
      y = 1'b1;
      tick();                              // N+3
      rst = 1'b0;
      y = 1'b0;
      check("rsth_x",      x,       4'b0000);
      check("rsth_ready",  ready,   1'b1);
      check("rsth_evt",    evt_cnt, 8'd0);
      check("rsth_active", active,  1'b0);
      tick();
      check("rsth_x_after", x, 4'b0000);

      // 300 acceptances saturate evt_cnt at 255
      for (int i = 1; i <= 300; i++) begin
         set_code(2'(i));
         y = 1'b1;
         tick();
         y = 1'b0;
         tick();
         tick();
         tick();
         tick();
         if (i == 254) check("sat_evt_254", evt_cnt, 8'd254);
         if (i == 255) check("sat_evt_255", evt_cnt, 8'd255);
      end
      check("sat_evt_300", evt_cnt, 8'd255);
      check("sat_ready",   ready,   1'b1);

      // HOLD_CYCLES = 1 with y held high: accept every 2 cycles
      check("h1_rst_ready", ready_1, 1'b1);
      z1_1 = 1'b1;
      z2_1 = 1'b1;
      y_1  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i % 2 == 0) begin
            check("h1_x_on",    x_1,       4'b1000);
            check("h1_ready0",  ready_1,   1'b0);
            check("h1_evt",     evt_cnt_1, 32'(i / 2 + 1));
         end else begin
            check("h1_x_off",   x_1,       4'b0000);
            check("h1_ready1",  ready_1,   1'b1);
         end
         check("h1_ovr", ovr_1, (i >= 1) ? 1'b1 : 1'b0);
      end
      y_1 = 1'b0;
      tick();
      tick();
      check("h1_idle_x",   x_1,       4'b0000);
      check("h1_final_evt", evt_cnt_1, 8'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decoder_x4.md
DECODER_X4 -- requirements
Module: decoder_x4

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles each decoded one-hot output is held (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL have port z1, input, 1, the code MSB, as produced by the 4-input priority encoder.
REQ-005 SHALL have port z2, input, 1, the code LSB.
REQ-006 SHALL have port y, input, 1, the code-valid strobe (encoder "any input active").
REQ-007 SHALL have port clr_ovr, input, 1, which clears the sticky overrun flag.
REQ-008 SHALL have port ready, output, 1, asserted when a code will be accepted this cycle.
REQ-009 SHALL have port x, output, 4, the registered one-hot decoded output.
REQ-010 SHALL have port active, output, 1, asserted while x is non-zero.
REQ-011 SHALL have port ovr, output, 1, the sticky overrun flag.
REQ-012 SHALL have port evt_cnt, output, 8, the count of accepted codes, saturating.

Function
REQ-013 SHALL implement states IDLE and HOLD; ready = 1 exactly when state is IDLE (combinational from state).
REQ-014 SHALL accept a code in cycle N when state = IDLE and y = 1: latch {z1,z2}, load the hold counter with HOLD_CYCLES-1, and enter HOLD at N+1.
REQ-015 SHALL drive x[{z1,z2}] = 1 with all other x bits 0 during cycles N+1 through N+HOLD_CYCLES inclusive; x = 4'b0000 at all other times.
REQ-016 SHALL decrement the hold counter once per cycle in HOLD, and return to IDLE in the cycle after the counter reads 0.
REQ-017 SHALL, for HOLD_CYCLES = 1, hold x for exactly one cycle (N+1) and be IDLE at N+2.
REQ-018 SHALL use a minimum spacing of HOLD_CYCLES+1 cycles between consecutive acceptances, so back-to-back codes see one idle cycle with x = 0.
REQ-019 SHALL ignore the z1 and z2 values when y = 0, with no state change.
REQ-020 SHALL NOT accept a code when y = 1 while ready = 0; x and the counter SHALL continue unaffected, and ovr SHALL be set to 1 from the next cycle.
REQ-021 SHALL keep ovr at 1 until a cycle with clr_ovr = 1 and no new overrun, and clear it on the following edge; a simultaneous overrun and clr_ovr SHALL leave ovr = 1 (set wins).
REQ-022 SHALL increment evt_cnt by 1 on each acceptance, registered with x, and saturate at 255 with no wrap.
REQ-023 SHALL make active equal to the OR of x at all times.

Reset
REQ-024 SHALL, on rst = 1 at a rising edge, set state = IDLE, x = 0, active = 0, ovr = 0, evt_cnt = 0, and hold counter = 0, regardless of the current state.
REQ-025 SHALL give rst priority over y and clr_ovr, abort any HOLD in progress (x = 0 from the next cycle), and keep ready = 1 from the cycle after reset.

Structure
REQ-026 SHALL place the state encodings (IDLE, HOLD), the HOLD_CYCLES default, and the counter widths (8) in the shared project package.
REQ-027 SHALL implement the hold counter as a sub-module hold_timer, with ports clk, rst, load, load_val[7:0] and done; the FSM, decode, overrun and event-count logic SHALL stay in decoder_x4.

Verification
REQ-028 SHALL cover: reset, then {z1,z2} = 2'b10 with y = 1 at N -> x = 4'b0100 at N+1..N+4, 0 at N+5, and evt_cnt = 1.
REQ-029 SHALL cover: codes 00, 01, 10 and 11 each accepted in turn -> x = 0001, 0010, 0100 and 1000 respectively, each held for 4 cycles with one gap cycle between them.
REQ-030 SHALL cover: y = 1 at N+2 during a HOLD -> the code is ignored, x is unchanged, ovr = 1 at N+3; then clr_ovr pulsed alone -> ovr = 0 the next cycle.
REQ-031 SHALL cover: overrun and clr_ovr in the same cycle -> ovr = 1.
REQ-032 SHALL cover: rst asserted at N+2 of a HOLD -> x = 0, ready = 1, evt_cnt = 0 at N+3.
REQ-033 SHALL cover: 300 acceptances -> evt_cnt = 255; and with HOLD_CYCLES = 1, y held high continuously -> an acceptance every 2 cycles and ovr set.
